// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit ALU among NUM_REQ requesters.
// Latches the winner's operation, drives the ALU, waits for done (with timeout) and returns the result.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [2*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [15:0]            resp_result,
    output logic                   resp_error,
    output logic                   busy,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [1:0]             alu_op_sel,
    output logic                   alu_load,
    input  logic [15:0]            alu_result,
    input  logic                   alu_done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW    = IDX_W + 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic [IDX_W-1:0]       owner_q;
    logic [TMR_W-1:0]       timer_q;
    logic [7:0]             alu_a_q;
    logic [7:0]             alu_b_q;
    logic [1:0]             alu_op_q;
    logic                   alu_load_q;
    logic [NUM_REQ-1:0]     resp_valid_q;
    logic [15:0]            resp_result_q;
    logic                   resp_error_q;
    logic                   busy_q;

    logic [IDX_W-1:0]       grant_idx_c;
    logic [CW-1:0]          cand_c;
    logic                   any_req_c;
    logic [7:0]             win_a_c;
    logic [7:0]             win_b_c;
    logic [1:0]             win_op_c;
    logic                   div0_c;
    logic [NUM_REQ-1:0]     grant_oh_c;

    // Round-robin search: scan from last_grant+1 with wrap; the nearest valid requester wins.
    always_comb begin
        grant_idx_c = '0;
        cand_c      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_c = CW'(last_grant_q) + CW'(k);
            if (cand_c >= CW'(NUM_REQ)) begin
                cand_c = cand_c - CW'(NUM_REQ);
            end
            if (req_valid[cand_c[IDX_W-1:0]]) begin
                grant_idx_c = cand_c[IDX_W-1:0];
            end
        end
    end

    assign any_req_c  = |req_valid;
    assign win_a_c    = req_a[8*grant_idx_c +: 8];
    assign win_b_c    = req_b[8*grant_idx_c +: 8];
    assign win_op_c   = req_op[2*grant_idx_c +: 2];
    assign div0_c     = (win_op_c == 2'b11) && (win_b_c == 8'd0);
    assign grant_oh_c = NUM_REQ'(1) << grant_idx_c;
    assign req_ready  = (state_q == S_IDLE && any_req_c) ? grant_oh_c : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            owner_q       <= '0;
            timer_q       <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            alu_load_q    <= 1'b0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_error_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req_c) begin
                        owner_q  <= grant_idx_c;
                        alu_a_q  <= win_a_c;
                        alu_b_q  <= win_b_c;
                        alu_op_q <= win_op_c;
                        busy_q   <= 1'b1;
                        // Divide-by-zero bypasses the ALU and answers with an error next cycle
                        if (div0_c) begin
                            state_q       <= S_RESP;
                            resp_valid_q  <= grant_oh_c;
                            resp_result_q <= 16'hFFFF;
                            resp_error_q  <= 1'b1;
                        end else begin
                            state_q    <= S_ISSUE;
                            alu_load_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    alu_load_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        resp_result_q <= alu_result;
                        resp_error_q  <= 1'b0;
                        resp_valid_q  <= NUM_REQ'(1) << owner_q;
                        state_q       <= S_RESP;
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        resp_result_q <= 16'hFFFF;
                        resp_error_q  <= 1'b1;
                        resp_valid_q  <= NUM_REQ'(1) << owner_q;
                        state_q       <= S_RESP;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_RESP: begin
                    resp_valid_q <= '0;
                    last_grant_q <= owner_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_error  = resp_error_q;
    assign busy        = busy_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op_sel  = alu_op_q;
    assign alu_load    = alu_load_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: arbitration order, latency, divide-by-zero, timeout and reset.
module tb_alu_req_arbiter;

    localparam int unsigned NR = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [8*NR-1:0]   req_a = '0;
    logic [8*NR-1:0]   req_b = '0;
    logic [2*NR-1:0]   req_op = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [15:0]       resp_result;
    logic              resp_error;
    logic              busy;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [1:0]        alu_op_sel;
    logic              alu_load;
    logic [15:0]       alu_result = '0;
    logic              alu_done = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    logic alu_en = 1'b1;
    logic load_prev = 1'b0;

    alu_req_arbiter #(.NUM_REQ(NR), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
        .resp_error(resp_error), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel), .alu_load(alu_load),
        .alu_result(alu_result), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    // Fixed-latency ALU: done is raised for one cycle, the cycle after the load pulse
    always @(posedge clk) begin
        #1;
        alu_done = 1'b0;
        if (load_prev && alu_en) begin
            alu_done = 1'b1;
            case (alu_op_sel)
                2'b00:   alu_result = 16'(alu_a) + 16'(alu_b);
                2'b01:   alu_result = 16'(alu_a) - 16'(alu_b);
                2'b10:   alu_result = 16'(alu_a) * 16'(alu_b);
                default: alu_result = (alu_b == 8'd0) ? 16'hFFFF : 16'(alu_a) / 16'(alu_b);
            endcase
        end
        load_prev = alu_load;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        req_valid[i]      = 1'b1;
        req_a[i*8 +: 8]   = a;
        req_b[i*8 +: 8]   = b;
        req_op[i*2 +: 2]  = op;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n   = 1'b1;
    endtask

    function automatic logic [63:0] out_bus();
        return {19'b0, req_ready, resp_valid, resp_result, resp_error, busy,
                alu_a, alu_b, alu_op_sel, alu_load};
    endfunction

    initial begin
        // Reset values
        tick();
        #1;
        chk("reset_outputs", out_bus(), 64'd0);
        do_reset();

        // Single request: requester 1 ADD 1+1
        tick();
        set_req(1, 8'd1, 8'd1, 2'b00);
        #1;
        chk("t1_ready", 64'(req_ready), 64'b0010);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        tick();
        req_valid = '0;
        #1;
        chk("t1_load", 64'(alu_load), 64'd1);
        chk("t1_operands", 64'({alu_a, alu_b, alu_op_sel}), 64'({8'd1, 8'd1, 2'b00}));
        chk("t1_ready_busy", 64'(req_ready), 64'd0);
        tick();
        #1;
        chk("t1_load_once", 64'(alu_load), 64'd0);
        chk("t1_no_early_resp", 64'(resp_valid), 64'd0);
        tick();
        #1;
        chk("t1_resp", 64'({resp_valid, resp_result, resp_error}), 64'({4'b0010, 16'd2, 1'b0}));
        tick();
        #1;
        chk("t1_resp_drop", 64'(resp_valid), 64'd0);
        chk("t1_result_hold", 64'(resp_result), 64'd2);
        chk("t1_idle", 64'(busy), 64'd0);

        // Simultaneous 0 (SUB 2-1) and 2 (MUL 2*2) after reset
        do_reset();
        tick();
        set_req(0, 8'd2, 8'd1, 2'b01);
        set_req(2, 8'd2, 8'd2, 2'b10);
        #1;
        chk("t2_ready0", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        #1;
        chk("t2_resp0", 64'({resp_valid, resp_result, resp_error}), 64'({4'b0001, 16'd1, 1'b0}));
        tick();
        #1;
        chk("t2_ready2", 64'(req_ready), 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        #1;
        chk("t2_resp2", 64'({resp_valid, resp_result, resp_error}), 64'({4'b0100, 16'd4, 1'b0}));
        tick();
        set_req(0, 8'd9, 8'd9, 2'b00);
        set_req(1, 8'd9, 8'd9, 2'b00);
        set_req(3, 8'd5, 8'd6, 2'b00);
        #1;
        chk("t2_next_from3", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        chk("t2_resp3", 64'({resp_valid, resp_result}), 64'({4'b1000, 16'd11}));

        // All four continuously valid: rotation 0,1,2,3,0,1
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd3, 2'b00);
        for (int k = 0; k < 6; k++) begin
            int e;
            e = k % 4;
            #1;
            chk($sformatf("t3_grant%0d", k), 64'(req_ready), 64'(4'b0001 << e));
            chk($sformatf("t3_idle%0d", k), 64'(busy), 64'd0);
            tick();
            #1;
            chk($sformatf("t3_busy%0d", k), 64'({busy, req_ready}), 64'({1'b1, 4'b0000}));
            tick();
            tick();
            #1;
            chk($sformatf("t3_resp%0d", k), 64'({resp_valid, resp_result}),
                64'({4'(4'b0001 << e), 16'(e + 4)}));
            tick();
        end
        req_valid = '0;

        // Divide by zero on requester 2, then a normal divide
        set_req(2, 8'd4, 8'd0, 2'b11);
        #1;
        chk("t4_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("t4_no_load", 64'(alu_load), 64'd0);
        chk("t4_resp", 64'({resp_valid, resp_result, resp_error}), 64'({4'b0100, 16'hFFFF, 1'b1}));
        tick();
        #1;
        chk("t4_after", 64'({resp_valid, busy, alu_load}), 64'd0);
        tick();
        set_req(2, 8'd4, 8'd2, 2'b11);
        #1;
        chk("t4b_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("t4b_load", 64'(alu_load), 64'd1);
        tick();
        tick();
        #1;
        chk("t4b_resp", 64'({resp_valid, resp_result, resp_error}), 64'({4'b0100, 16'd2, 1'b0}));

        // Timeout: ALU never answers
        tick();
        alu_en = 1'b0;
        set_req(0, 8'd1, 8'd2, 2'b00);
        #1;
        chk("t5_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        repeat (64) tick();
        #1;
        chk("t5_still_wait", 64'({resp_valid, busy}), 64'({4'b0000, 1'b1}));
        tick();
        #1;
        chk("t5_timeout", 64'({resp_valid, resp_result, resp_error}), 64'({4'b0001, 16'hFFFF, 1'b1}));
        tick();
        alu_en = 1'b1;
        set_req(3, 8'd7, 8'd8, 2'b00);
        #1;
        chk("t5b_ready", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        chk("t5b_resp", 64'({resp_valid, resp_result, resp_error}), 64'({4'b1000, 16'd15, 1'b0}));

        // Complete an op on 2 so the pointer sits at 2, then reset during WAIT of an op on 1
        tick();
        set_req(2, 8'd3, 8'd3, 2'b10);
        #1;
        chk("t6_ready2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        chk("t6_resp2", 64'({resp_valid, resp_result}), 64'({4'b0100, 16'd9}));
        tick();
        alu_en = 1'b0;
        set_req(1, 8'd1, 8'd1, 2'b00);
        #1;
        chk("t6_ready1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("t6_in_wait", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset", out_bus(), 64'd0);
        tick();
        #1;
        chk("t6_no_resp", 64'(resp_valid), 64'd0);
        tick();
        reset_n = 1'b1;
        alu_en  = 1'b1;
        set_req(0, 8'd6, 8'd2, 2'b01);
        set_req(3, 8'd1, 8'd1, 2'b00);
        #1;
        chk("t6_prio0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        chk("t6_resp0", 64'({resp_valid, resp_result, resp_error}), 64'({4'b0001, 16'd4, 1'b0}));
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one alu_8bit datapath among NUM_REQ requesters.
- Each requester presents operands and an opcode with a valid/ready handshake.
- The arbiter latches the winner's operation, drives the ALU load/operand interface, and waits for done (bounded by a timeout).
- It returns the 16-bit result to the owning requester with a one-cycle response strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles spent in WAIT before the operation is aborted with an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_a  input  8*NUM_REQ  operand A; requester i occupies bits [8i+7:8i].
- req_b  input  8*NUM_REQ  operand B, same packing.
- req_op  input  2*NUM_REQ  op select, packed [2i+1:2i]; 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- req_ready  output  NUM_REQ  one-hot accept strobe.
- resp_valid  output  NUM_REQ  one-hot, one-cycle result strobe to the owning requester.
- resp_result  output  16  result; valid while any resp_valid bit is high.
- resp_error  output  1  qualifies resp_valid: divide-by-zero or timeout.
- busy  output  1  high in any state other than IDLE.
- alu_a  output  8  operand A to ALU.
- alu_b  output  8  operand B to ALU.
- alu_op_sel  output  2  op select to ALU.
- alu_load  output  1  one-cycle start pulse to ALU.
- alu_result  input  16  ALU result.
- alu_done  input  1  ALU completion flag.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state=IDLE.
  - All outputs 0, including alu_a/alu_b/alu_op_sel.
  - Timer 0.
  - Priority pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching from last_grant+1 upward with wrap-around.
  - req_ready[winner] is asserted combinationally in that same cycle; the transfer completes on that edge.
  - Winner's a/b/op are latched and owner index stored.
  - If op==11 and b==0, go to RESP with error; otherwise go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - alu_load=1 for exactly this cycle; go to WAIT with timer cleared.
  - alu_a/alu_b/alu_op_sel hold the latched values from ISSUE until the next accept; they do not change in WAIT or RESP.
- WAIT:
  - alu_done is sampled each cycle.
  - When high, alu_result is captured into resp_result, resp_error=0, go to RESP.
  - Otherwise the timer increments; when timer==TIMEOUT-1 with done still low, resp_result=16'hFFFF, resp_error=1, go to RESP.
  - alu_done is ignored in IDLE, ISSUE and RESP.
- RESP:
  - resp_valid[owner]=1 for one cycle.
  - last_grant updates to owner; go to IDLE.
  - resp_result and resp_error hold until the next RESP.
  - resp_valid is 0 outside RESP.
- Divide-by-zero: the ALU is never loaded; resp_result=16'hFFFF, resp_error=1.
- Latency:
  - Accept at cycle T, alu_load at T+1, earliest done sample at T+2, resp_valid at T+3.
  - Divide-by-zero: resp_valid at T+1.
- Throughput: the next accept can occur at the earliest in the cycle after RESP; there is no back-to-back overlap.
- Requests arriving while busy stay pending; requesters hold valid and operands stable until ready.
- A requester may drop req_valid before being granted without effect.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Reset mid-operation (any state): immediately return to IDLE with reset values. The in-flight operation is discarded and no response is issued.

Test Plan:
- Single request: requester 1 sends A=1, B=1, op=00 → req_ready[1] at T, alu_load at T+1, ALU done → resp_valid[1] at T+3, resp_result=2, resp_error=0.
- Simultaneous requests 0 (SUB 2-1) and 2 (MUL 2*2) after reset → requester 0 served first (result 1), then requester 2 (result 4); next round starts search at requester 3.
- All four requesters valid continuously → grant order 0,1,2,3,0,1; exactly one req_ready per accept; busy high between accepts.
- DIV A=4, B=0 → no alu_load pulse, resp_valid at T+1, resp_result=16'hFFFF, resp_error=1; DIV A=4, B=2 → result 2, resp_error=0.
- Timeout: hold alu_done low with TIMEOUT=64 → resp_valid after exactly 64 WAIT cycles, resp_result=16'hFFFF, resp_error=1; the next request completes normally.
- Reset asserted during WAIT → all outputs 0 asynchronously, no resp_valid; after release requester 0 has first priority.
